// File: rtl/seq_detect_fsm.sv
// rtl/seq_detect_fsm.sv - serial pattern detector with Mealy strobe, Moore pulse and saturating hit counter
module seq_detect_fsm #(
    parameter int                 PAT_LEN   = 4,
    parameter int                 CNT_W     = 8,
    parameter logic [PAT_LEN-1:0] PAT_RESET = 4'b1011
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               overlap,
    input  logic               din,
    input  logic               din_valid,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               match_mealy,
    output logic               match_moore,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy
);

    localparam int             FW       = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2,
        HIT   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PAT_LEN-2:0]   window_q, window_d;
    logic [FW-1:0]        fill_cnt_q, fill_cnt_d;
    logic [PAT_LEN-1:0]   pat_reg_q, pat_reg_d;
    logic [CNT_W-1:0]     match_cnt_q, match_cnt_d;
    logic                 match_moore_q, match_moore_d;
    logic                 busy_q, busy_d;

    logic                 accept;
    logic                 match_now;
    logic [PAT_LEN-1:0]   shifted;

    always_comb begin
        accept    = en & din_valid & ~pat_load;
        shifted   = {window_q, din};
        match_now = accept && (fill_cnt_q == FILL_MAX) && (shifted == pat_reg_q);
    end

    always_comb begin
        state_d    = state_q;
        window_d   = window_q;
        fill_cnt_d = fill_cnt_q;
        pat_reg_d  = pat_reg_q;

        if (pat_load) begin
            pat_reg_d  = pat_in;
            fill_cnt_d = '0;
            window_d   = '0;
            state_d    = en ? FILL : IDLE;
        end else if (!en) begin
            state_d    = IDLE;
            fill_cnt_d = '0;
        end else begin
            if (accept) begin
                window_d   = shifted[PAT_LEN-2:0];
                fill_cnt_d = (fill_cnt_q == FILL_MAX) ? fill_cnt_q : fill_cnt_q + 1'b1;
            end
            if (match_now) begin
                state_d = HIT;
                // Non-overlapping mode discards the history that formed this hit.
                if (!overlap) begin
                    fill_cnt_d = '0;
                end
            end else begin
                // Covers IDLE->FILL, FILL->ARMED, and HIT exit (ARMED or FILL by fill level).
                state_d = (fill_cnt_d == FILL_MAX) ? ARMED : FILL;
            end
        end
    end

    always_comb begin
        match_cnt_d = match_cnt_q;
        if (cnt_clr) begin
            match_cnt_d = {{(CNT_W-1){1'b0}}, match_now};
        end else if (match_now && (match_cnt_q != CNT_MAX)) begin
            match_cnt_d = match_cnt_q + 1'b1;
        end
    end

    always_comb begin
        match_moore_d = (state_d == HIT);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            window_q      <= '0;
            fill_cnt_q    <= '0;
            pat_reg_q     <= PAT_RESET;
            match_cnt_q   <= '0;
            match_moore_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            window_q      <= window_d;
            fill_cnt_q    <= fill_cnt_d;
            pat_reg_q     <= pat_reg_d;
            match_cnt_q   <= match_cnt_d;
            match_moore_q <= match_moore_d;
            busy_q        <= busy_d;
        end
    end

    assign match_mealy = match_now;
    assign match_moore = match_moore_q;
    assign match_cnt   = match_cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb/tb_seq_detect_fsm.sv - directed self-checking bench for seq_detect_fsm
module tb_seq_detect_fsm;

    logic       clk = 1'b0;
    logic       reset, en, overlap, din, din_valid, pat_load, cnt_clr;
    logic [3:0] pat_in;
    logic       match_mealy, match_moore, busy;
    logic [7:0] match_cnt;
    logic       mealy2, moore2, busy2;
    logic [1:0] cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    seq_detect_fsm #(.PAT_LEN(4), .CNT_W(8), .PAT_RESET(4'b1011)) dut (
        .clk(clk), .reset(reset), .en(en), .overlap(overlap), .din(din),
        .din_valid(din_valid), .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .match_mealy(match_mealy), .match_moore(match_moore), .match_cnt(match_cnt), .busy(busy)
    );

    seq_detect_fsm #(.PAT_LEN(4), .CNT_W(2), .PAT_RESET(4'b1011)) dut2 (
        .clk(clk), .reset(reset), .en(en), .overlap(overlap), .din(din),
        .din_valid(din_valid), .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .match_mealy(mealy2), .match_moore(moore2), .match_cnt(cnt2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic e, d, v, ld, clr, input logic [3:0] p);
        @(negedge clk);
        en = e; din = d; din_valid = v; pat_load = ld; cnt_clr = clr; pat_in = p;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b0; din = 1'b0; din_valid = 1'b0;
        pat_load = 1'b0; cnt_clr = 1'b0; pat_in = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Element i of a stream sits at bit [n-1-i] (reads left to right).
    task automatic run_stream(input logic [15:0] bits, input logic [15:0] valid, input int n,
                              output logic [15:0] mm, output logic [15:0] mo);
        mm = '0;
        mo = '0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, bits[n-1-i], valid[n-1-i], 1'b0, 1'b0, pat_in);
            mm[n-1-i] = match_mealy;
            mo[n-1-i] = match_moore;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b1; din = 1'b0; din_valid = 1'b1;
        pat_load = 1'b0; cnt_clr = 1'b0; pat_in = 4'b0000; overlap = 1'b1;
        repeat (3) begin
            @(negedge clk);
            din = ~din;
        end
        #1;
        n_cmp++; if (match_mealy !== 1'b0) begin n_bad++; $display("FAIL reset_mealy: got %b expected 0", match_mealy); end
        n_cmp++; if (match_moore !== 1'b0) begin n_bad++; $display("FAIL reset_moore: got %b expected 0", match_moore); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (match_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
        n_cmp++; if ({mealy2, moore2, busy2, cnt2} !== 5'b0) begin n_bad++; $display("FAIL reset_dut2: got %b expected 00000", {mealy2, moore2, busy2, cnt2}); end
        @(negedge clk);
        reset = 1'b1; din = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL release_busy: got %b expected 1", busy); end
    endtask

    task automatic test_overlap();
        logic [15:0] mm, mo;
        do_reset();
        overlap = 1'b1;
        run_stream(16'b10110110, 16'b11111110, 8, mm, mo);
        n_cmp++; if (mm !== 16'b00010010) begin n_bad++; $display("FAIL ovl_mealy: got %b expected %b", mm, 16'b00010010); end
        n_cmp++; if (mo !== 16'b00001001) begin n_bad++; $display("FAIL ovl_moore: got %b expected %b", mo, 16'b00001001); end
        n_cmp++; if (match_cnt !== 8'd2) begin n_bad++; $display("FAIL ovl_cnt: got %0d expected 2", match_cnt); end
    endtask

    task automatic test_non_overlap();
        logic [15:0] mm, mo;
        do_reset();
        overlap = 1'b0;
        run_stream(16'b10110110, 16'b11111110, 8, mm, mo);
        n_cmp++; if (mm !== 16'b00010000) begin n_bad++; $display("FAIL novl_mealy: got %b expected %b", mm, 16'b00010000); end
        n_cmp++; if (mo !== 16'b00001000) begin n_bad++; $display("FAIL novl_moore: got %b expected %b", mo, 16'b00001000); end
        n_cmp++; if (match_cnt !== 8'd1) begin n_bad++; $display("FAIL novl_cnt: got %0d expected 1", match_cnt); end
        do_reset();
        overlap = 1'b0;
        run_stream(16'b101110110, 16'b111111110, 9, mm, mo);
        n_cmp++; if (mm !== 16'b000100010) begin n_bad++; $display("FAIL novl2_mealy: got %b expected %b", mm, 16'b000100010); end
        n_cmp++; if (mo !== 16'b000010001) begin n_bad++; $display("FAIL novl2_moore: got %b expected %b", mo, 16'b000010001); end
        n_cmp++; if (match_cnt !== 8'd2) begin n_bad++; $display("FAIL novl2_cnt: got %0d expected 2", match_cnt); end
    endtask

    task automatic test_gaps();
        logic [15:0] mm, mo;
        logic [8:0]  bits, ens;
        logic [15:0] m2;
        do_reset();
        overlap = 1'b1;
        run_stream(16'b10001010, 16'b10101010, 8, mm, mo);
        n_cmp++; if (mm !== 16'b00000010) begin n_bad++; $display("FAIL gap_mealy: got %b expected %b", mm, 16'b00000010); end
        n_cmp++; if (mo !== 16'b00000001) begin n_bad++; $display("FAIL gap_moore: got %b expected %b", mo, 16'b00000001); end
        n_cmp++; if (match_cnt !== 8'd1) begin n_bad++; $display("FAIL gap_cnt: got %0d expected 1", match_cnt); end
        do_reset();
        overlap = 1'b1;
        bits = 9'b101010110;
        ens  = 9'b111011111;
        m2   = '0;
        for (int i = 0; i < 9; i++) begin
            drive(ens[8-i], bits[8-i], (i != 8), 1'b0, 1'b0, pat_in);
            m2[8-i] = match_mealy;
            if (i == 4) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL en_drop_busy: got %b expected 0", busy); end
            end
        end
        n_cmp++; if (m2 !== 16'b000000010) begin n_bad++; $display("FAIL en_drop_mealy: got %b expected %b", m2, 16'b000000010); end
        n_cmp++; if (match_cnt !== 8'd1) begin n_bad++; $display("FAIL en_drop_cnt: got %0d expected 1", match_cnt); end
    endtask

    task automatic test_counter();
        logic [15:0] mm, mo;
        do_reset();
        overlap = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111);
        run_stream(16'b111111110, 16'b111111110, 9, mm, mo);
        n_cmp++; if (mm !== 16'b000111110) begin n_bad++; $display("FAIL cnt_mealy: got %b expected %b", mm, 16'b000111110); end
        n_cmp++; if (mo !== 16'b000011111) begin n_bad++; $display("FAIL cnt_moore: got %b expected %b", mo, 16'b000011111); end
        n_cmp++; if (match_cnt !== 8'd5) begin n_bad++; $display("FAIL cnt_wide: got %0d expected 5", match_cnt); end
        n_cmp++; if (cnt2 !== 2'd3) begin n_bad++; $display("FAIL cnt_sat: got %0d expected 3", cnt2); end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1111);
        n_cmp++; if (match_mealy !== 1'b1) begin n_bad++; $display("FAIL clr_hit_mealy: got %b expected 1", match_mealy); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
        n_cmp++; if (match_cnt !== 8'd1) begin n_bad++; $display("FAIL clr_hit_cnt: got %0d expected 1", match_cnt); end
        n_cmp++; if (cnt2 !== 2'd1) begin n_bad++; $display("FAIL clr_hit_cnt2: got %0d expected 1", cnt2); end
        n_cmp++; if (match_moore !== 1'b1) begin n_bad++; $display("FAIL clr_hit_moore: got %b expected 1", match_moore); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
        n_cmp++; if (match_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_only_cnt: got %0d expected 0", match_cnt); end
    endtask

    task automatic test_load_reset();
        logic [7:0] bits, ld;
        logic [7:0] mm;
        do_reset();
        overlap = 1'b1;
        bits = 8'b10110110;
        ld   = 8'b00010000;
        mm   = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, bits[7-i], 1'b1, ld[7-i], 1'b0, (i >= 3) ? 4'b0110 : 4'b0000);
            mm[7-i] = match_mealy;
        end
        n_cmp++; if (mm !== 8'b00000001) begin n_bad++; $display("FAIL load_mealy: got %b expected %b", mm, 8'b00000001); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110);
        n_cmp++; if (match_moore !== 1'b1) begin n_bad++; $display("FAIL load_moore: got %b expected 1", match_moore); end
        n_cmp++; if (match_cnt !== 8'd1) begin n_bad++; $display("FAIL load_cnt: got %0d expected 1", match_cnt); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (match_moore !== 1'b0) begin n_bad++; $display("FAIL async_moore: got %b expected 0", match_moore); end
        n_cmp++; if (match_cnt !== 8'd0) begin n_bad++; $display("FAIL async_cnt: got %0d expected 0", match_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_busy: got %b expected 0", busy); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; overlap = 1'b1; din = 1'b0; din_valid = 1'b0;
        pat_load = 1'b0; cnt_clr = 1'b0; pat_in = 4'b0000;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_counter();
        test_load_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
